boolean1_solver: RTL and testbench

BOOLEAN1_SOLVER -- requirements
Module: boolean1_solver

---
 rtl/boolean1_solver.sv | 118 +++++++++++
 tb/tb_boolean1_solver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boolean1_solver.sv
// boolean1_solver: enumerates every {a,b,c} for which f(a,b,c) equals a
// requested target and streams the matches out over a valid/ready port.
module boolean1_solver (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       target,
    output logic [2:0] out_abc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic       tgt_q;
    logic       tgt_d;
    logic [2:0] abc_q;
    logic [2:0] abc_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic       f_val;
    logic       hit;
    logic       last;
    logic       hs;

    // f(a,b,c) = (~a | ~b) & ~c, evaluated on the current index
    function automatic logic f_eval(input logic [2:0] v);
        return (~v[2] | ~v[1]) & ~v[0];
    endfunction

    assign f_val = f_eval(idx_q);
    assign hit   = (f_val == tgt_q);
    assign last  = (idx_q == 3'd7);
    assign hs    = (state_q == EMIT) && out_ready;

    // State and datapath registers; reset aborts any search in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            tgt_q   <= 1'b0;
            abc_q   <= 3'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            abc_q   <= abc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; one index is examined per SCAN cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        abc_d   = abc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    abc_d   = idx_q;
                    state_d = EMIT;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            EMIT: begin
                if (hs) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_abc   = abc_q;
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == SCAN) || (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign count     = cnt_q;

endmodule

// File: tb/tb_boolean1_solver.sv
// Randomised scoreboard bench for boolean1_solver with directed
// latency, backpressure, restart, reset and target-change scenarios.
module tb_boolean1_solver;

    logic       clk;
    logic       rst;
    logic       start;
    logic       target;
    logic [2:0] out_abc;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    int sol_q[$];
    int cnt_q[$];

    logic       pv;
    logic       pr;
    logic [2:0] pabc;

    boolean1_solver dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .target   (target),
        .out_abc  (out_abc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: f = NOT(a AND b) AND NOT c, from the boolean definition
    function automatic bit f_ref(input int v);
        bit a;
        bit b;
        bit c;
        a = ((v / 4) % 2) == 1;
        b = ((v / 2) % 2) == 1;
        c = (v % 2) == 1;
        return !(a && b) && !c;
    endfunction

    function automatic int n_sol(input bit t);
        int n = 0;
        for (int v = 0; v < 8; v++)
            if (f_ref(v) == t) n++;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_search(input bit t);
        for (int v = 0; v < 8; v++)
            if (f_ref(v) == t) sol_q.push_back(v);
        cnt_q.push_back(n_sol(t));
    endtask

    // Monitor: pops expected solutions on handshakes and counts on done
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_abc", int'(out_abc), int'(pabc));
            end
            if (out_valid && out_ready) begin
                if (sol_q.size() == 0) begin
                    chk("unexpected_emit", int'(out_abc), -1);
                end else begin
                    chk("emit_abc", int'(out_abc), sol_q.pop_front());
                end
            end
            if (done) begin
                chk("done_valid_low", int'(out_valid), 0);
                chk("done_busy_low", int'(busy), 0);
                if (cnt_q.size() == 0) begin
                    chk("unexpected_done", int'(count), -1);
                end else begin
                    chk("done_count", int'(count), cnt_q.pop_front());
                end
            end
            pv   = out_valid;
            pr   = out_ready;
            pabc = out_abc;
        end
    end

    // rmode: 0 always ready, 1 random ready, 2 stall first emit 5 cycles
    task automatic run_search(input bit t, input int rmode,
                              input bit tog, input int exp_lat);
        int n;
        int stalls;
        int vrun;
        bit seen;
        n      = 0;
        stalls = 0;
        vrun   = 0;
        seen   = 1'b0;
        @(posedge clk);
        #1;
        start  = 1'b1;
        target = t;
        push_search(t);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!seen && n < 200) begin
            if (tog) target = ~target;
            if (rmode == 0) begin
                out_ready = 1'b1;
            end else if (rmode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (out_valid && stalls < 5) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            n++;
            if (out_valid && out_abc == 3'd0) vrun++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("done_seen", int'(seen), 1);
        if (exp_lat > 0) chk("done_latency", n, exp_lat);
        if (rmode == 2) chk("stall_valid_cycles", vrun, 6);
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sol_q.delete();
        cnt_q.delete();
    endtask

    initial begin
        int n;
        int d1;
        int d2;
        int nd;
        int extra;
        rst       = 1'b1;
        start     = 1'b0;
        target    = 1'b0;
        out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_abc", int'(out_abc), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);

        // target=1 full throughput: 8 scans + 3 emits, done in cycle 12
        run_search(1'b1, 0, 1'b0, 8 + n_sol(1'b1) + 1);
        @(negedge clk);
        chk("count_held_t1", int'(count), 3);

        // target=0 full throughput: done in cycle 14
        run_search(1'b0, 0, 1'b0, 8 + n_sol(1'b0) + 1);
        @(negedge clk);
        chk("count_held_t0", int'(count), 5);

        // backpressure on the first emit adds 5 cycles
        run_search(1'b1, 2, 1'b0, 8 + n_sol(1'b1) + 1 + 5);

        // target toggling after acceptance
        run_search(1'b0, 0, 1'b1, 8 + n_sol(1'b0) + 1);

        // start held high: back-to-back searches with one IDLE cycle
        @(posedge clk);
        #1;
        target = 1'b1;
        start  = 1'b1;
        push_search(1'b1);
        push_search(1'b1);
        n  = 0;
        nd = 0;
        d1 = 0;
        d2 = 0;
        while (nd < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (done) begin
                nd++;
                if (nd == 1) d1 = n;
                else begin
                    d2    = n;
                    start = 1'b0;
                end
            end
        end
        chk("restart_dones", nd, 2);
        chk("restart_gap", d2 - d1, 8 + n_sol(1'b1) + 1 + 1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        chk("no_queued_start", extra, 0);

        // reset while holding solution 2 under backpressure
        @(posedge clk);
        #1;
        target    = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        push_search(1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_abc == 3'd2) && n < 100) begin
            out_ready = !(out_valid && out_abc == 3'd2);
            if (out_valid && out_abc != 3'd0) out_ready = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        chk("reach_emit2", int'(out_valid && out_abc == 3'd2), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sol_q.delete();
        cnt_q.delete();
        @(negedge clk);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_abc", int'(out_abc), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || out_valid) extra++;
        end
        chk("abort_no_done", extra, 0);
        out_ready = 1'b1;

        // randomised searches with random backpressure
        for (int k = 0; k < 30; k++) begin
            run_search(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
        end
        repeat (3) @(negedge clk);
        chk("sol_queue_empty", sol_q.size(), 0);
        chk("cnt_queue_empty", cnt_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
